masked_sbox_layer_seq: RTL and testbench
========================================

Name: masked_sbox_layer_seq

Overview:
Serial sequencer for one masked S-box layer of the 3-share LED datapath, placed directly upstream of the 3-share masked PRESENT/LED S-box instance.
- Takes a 64-bit state in three Boolean shares.
- Issues its 16 nibbles one per cycle into the single pipelined S-box.
- Chains the S-box's inter-nibble refresh value from each nibble to the next.
- Collects the 3-share S-box outputs back into a 64-bit shared state and pulses done.

Parameters:
- LATENCY, 3: clock edges from the edge where the S-box samples sb_en/sb_in* to the edge where the matching sb_out* is valid for capture. Legal range 2..8.
- NIBBLES, 16: nibbles per layer. State width = 4*NIBBLES.

Ports:
- clk  in  1  — single clock, rising edge.
- rst  in  1  — synchronous, active-high reset.
- start  in  1  — begin a layer; sampled only in IDLE.
- state_in1/state_in2/state_in3  in  64 each  — input state shares; sampled on the start edge.
- rs_seed  in  8  — refresh value for nibble 0; sampled on the start edge.
- busy  out  1  — high from the start edge until done.
- done  out  1  — one-cycle pulse when state_out* is complete.
- state_out1/state_out2/state_out3  out  64 each  — output state shares.
- sb_in1/sb_in2/sb_in3  out  4 each  — nibble shares sent to the S-box.
- sb_en  out  1  — S-box input-register enable.
- sb_rs_out  in  8  — S-box refresh output.
- sb_rs_in  out  8  — S-box refresh input.
- sb_out1/sb_out2/sb_out3  in  4 each  — S-box output shares.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; all counters and valid pipes clear.
  - busy=0, done=0, sb_en=0, sb_in*=0, sb_rs_in=0, state_out*=0.
  - rst mid-operation aborts the layer; in-flight S-box results are never captured.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start=1 at edge E0:
  - latch state_in* into a share-wise shift buffer and rs_seed into the seed register;
  - clear issue_cnt; go to ISSUE; busy=1.
- ISSUE:
  - sb_en=1; sb_in* = buffer[4*issue_cnt+3 : 4*issue_cnt], low nibble first.
  - Nibble i is sampled by the S-box at edge E0+1+i.
  - issue_cnt increments each cycle. After nibble NIBBLES-1 is issued, go to DRAIN and set sb_en=0.
  - sb_in* returns to 0 whenever sb_en=0, so no stale shares are left on the bus.
- Valid pipe: a LATENCY-deep shift register carries a valid bit plus a 4-bit index alongside each issued nibble.
- Capture: when the valid bit reaches the pipe tail, sb_out* is written into state_out* at nibble position = index. Nibble i is written at edge E0+1+i+LATENCY.
- Refresh chaining:
  - The pipe stage-1 slot holds the nibble currently in the S-box F stage.
  - If that slot's index is 0, sb_rs_in = seed register.
  - Otherwise sb_rs_in = rs_hold, a register loaded every cycle from sb_rs_out while stage 1 is valid.
  - sb_rs_in = 0 when stage 1 is empty.
- DRAIN: wait until the pipe is empty, then go to DONE.
- DONE: done=1 for exactly one cycle, i.e. the cycle after edge E0+NIBBLES+LATENCY; busy=0 in the same cycle; return to IDLE.
- Timing: start to done = NIBBLES+LATENCY+1 cycles, which is 20 for the defaults.
- state_out* holds its value until the next start. Partial updates are visible while busy.
- start while busy (ISSUE/DRAIN/DONE) is ignored. start in the DONE cycle is also ignored; a new layer starts the cycle after done.
- start and rst asserted together: rst wins.
- No arithmetic beyond counters. issue_cnt is 4 bits and never wraps during ISSUE.

Optional Feature:
- Macro: SBOX_SEQ_ZEROIZE_EN.
- Defined: on the start edge, state_out1/2/3 clear to 0, and rs_hold clears to 0 at done. No share of the previous layer remains visible on outputs.
- Undefined: state_out* keeps the previous layer's values until they are overwritten nibble by nibble. rs_hold keeps its last value.

Test Plan:
- Shares state_in1=0x0123456789ABCDEF, state_in2=state_in3=0; S-box model = PRESENT S-box on the share XOR, with output shares (S,0,0); start -> done exactly 20 cycles after start; XOR of state_out* = 0xC56B90AD3EF84712 (nibble-wise PRESENT S-box).
- Random nonzero masks on shares 2 and 3, 100 random states -> XOR of state_out* equals the S-box layer of the unmasked state; sb_en high for exactly 16 consecutive cycles per layer.
- rs_seed=0xA5; S-box model drives sb_rs_out=0x10+index -> sb_rs_in sequence seen by stage 1 is 0xA5, 0x10, 0x11, …, 0x1E.
- Pulse start again 5 cycles after the first start -> ignored; single done; result unchanged.
- Assert rst for 1 cycle at cycle 10 of a layer -> busy=0, done never pulses, state_out*=0; a following start completes normally in 20 cycles.
- With SBOX_SEQ_ZEROIZE_EN defined, run layer A, then start layer B -> state_out*=0 on the cycle after the start edge. Without the macro -> layer A values persist until overwritten.

Source files
------------

// File: rtl/masked_sbox_layer_seq.sv
// masked_sbox_layer_seq: issues 16 shared nibbles serially into a pipelined masked S-box and gathers results; SBOX_SEQ_ZEROIZE_EN clears outputs on start and rs_hold at done
module masked_sbox_layer_seq #(
  parameter int LATENCY = 3,
  parameter int NIBBLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] state_in1,
  input  logic [4*NIBBLES-1:0] state_in2,
  input  logic [4*NIBBLES-1:0] state_in3,
  input  logic [7:0]           rs_seed,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] state_out1,
  output logic [4*NIBBLES-1:0] state_out2,
  output logic [4*NIBBLES-1:0] state_out3,
  output logic [3:0]           sb_in1,
  output logic [3:0]           sb_in2,
  output logic [3:0]           sb_in3,
  output logic                 sb_en,
  input  logic [7:0]           sb_rs_out,
  output logic [7:0]           sb_rs_in,
  input  logic [3:0]           sb_out1,
  input  logic [3:0]           sb_out2,
  input  logic [3:0]           sb_out3
);
  localparam int W = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] buf1_q, buf2_q, buf3_q, out1_q, out2_q, out3_q;
  logic [7:0] seed_q, rs_hold_q;
  logic [IW-1:0] cnt_q;
  logic [LATENCY-1:0] vld_q;
  logic [IW-1:0] idx_q [LATENCY];
  logic issue, last, launch;
  assign issue = state_q == ISSUE;
  assign last = cnt_q == IW'(NIBBLES - 1);
  assign launch = state_q == IDLE && start;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ISSUE : IDLE;
      ISSUE:   state_d = last ? DRAIN : ISSUE;
      DRAIN:   state_d = vld_q[LATENCY-2:0] == '0 ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  assign busy = issue || state_q == DRAIN;
  assign done = state_q == DONE;
  assign sb_en = issue;
  assign sb_in1 = issue ? buf1_q[4*cnt_q +: 4] : '0;
  assign sb_in2 = issue ? buf2_q[4*cnt_q +: 4] : '0;
  assign sb_in3 = issue ? buf3_q[4*cnt_q +: 4] : '0;
  // stage 1 mirrors the nibble in the S-box F stage; nibble 0 takes the seed, later ones the previous refresh
  assign sb_rs_in = !vld_q[0] ? '0 : idx_q[0] == '0 ? seed_q : rs_hold_q;
  assign state_out1 = out1_q;
  assign state_out2 = out2_q;
  assign state_out3 = out3_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      vld_q <= '0;
      for (int k = 0; k < LATENCY; k++) idx_q[k] <= '0;
      out1_q <= '0;
      out2_q <= '0;
      out3_q <= '0;
      rs_hold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= issue && !last ? cnt_q + 1'b1 : '0;
      vld_q <= {vld_q[LATENCY-2:0], issue};
      idx_q[0] <= cnt_q;
      for (int k = 1; k < LATENCY; k++) idx_q[k] <= idx_q[k-1];
      if (launch) begin
        buf1_q <= state_in1;
        buf2_q <= state_in2;
        buf3_q <= state_in3;
        seed_q <= rs_seed;
`ifdef SBOX_SEQ_ZEROIZE_EN
        out1_q <= '0;
        out2_q <= '0;
        out3_q <= '0;
`endif
      end
      if (vld_q[LATENCY-1]) begin
        out1_q[4*idx_q[LATENCY-1] +: 4] <= sb_out1;
        out2_q[4*idx_q[LATENCY-1] +: 4] <= sb_out2;
        out3_q[4*idx_q[LATENCY-1] +: 4] <= sb_out3;
      end
`ifdef SBOX_SEQ_ZEROIZE_EN
      if (vld_q[0]) rs_hold_q <= sb_rs_out;
      else if (state_q == DONE) rs_hold_q <= '0;
`else
      if (vld_q[0]) rs_hold_q <= sb_rs_out;
`endif
    end
  end
endmodule

// File: tb/tb_masked_sbox_layer_seq.sv
// tb_masked_sbox_layer_seq: scoreboard bench with a pipelined masked PRESENT S-box environment model
module tb_masked_sbox_layer_seq;
  localparam int L = 3;
  localparam int N = 16;
  logic clk = 0, rst = 1, start = 0;
  logic [63:0] state_in1 = '0, state_in2 = '0, state_in3 = '0;
  logic [7:0] rs_seed = '0;
  logic busy, done, sb_en;
  logic [63:0] state_out1, state_out2, state_out3;
  logic [3:0] sb_in1, sb_in2, sb_in3, sb_out1, sb_out2, sb_out3;
  logic [7:0] sb_rs_out, sb_rs_in;
  masked_sbox_layer_seq #(.LATENCY(L), .NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .state_in1(state_in1), .state_in2(state_in2), .state_in3(state_in3),
    .rs_seed(rs_seed), .busy(busy), .done(done),
    .state_out1(state_out1), .state_out2(state_out2), .state_out3(state_out3),
    .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3), .sb_en(sb_en),
    .sb_rs_out(sb_rs_out), .sb_rs_in(sb_rs_in),
    .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3)
  );
  always #5 clk = ~clk;
  int errs = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [63:0] o1, o2, o3, x; int t0;} exp_t;
  exp_t q[$];
  exp_t last_e;
  logic [63:0] cur_m2 = '0, cur_m3 = '0;
  logic [7:0] cur_seed = '0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask
  function automatic logic [3:0] sb(input logic [3:0] v);
    logic [63:0] t;
    t = 64'h21748FE3DA09B65C;
    return t[4*v +: 4];
  endfunction
  function automatic logic [63:0] layer(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb(s[4*i +: 4]);
    return r;
  endfunction
  logic [L-1:0] rv;
  logic [11:0] rd [L];
  logic [3:0] mcnt, ridx0, junk;
  always @(posedge clk) begin
    junk <= 4'($urandom);
    if (rst) begin
      rv <= '0;
      mcnt <= '0;
      ridx0 <= '0;
    end else begin
      rv <= {rv[L-2:0], sb_en};
      rd[0] <= {sb(sb_in1 ^ sb_in2 ^ sb_in3) ^ cur_m2[4*mcnt +: 4] ^ cur_m3[4*mcnt +: 4],
                cur_m2[4*mcnt +: 4], cur_m3[4*mcnt +: 4]};
      for (int k = 1; k < L; k++) rd[k] <= rd[k-1];
      ridx0 <= mcnt;
      if (sb_en) mcnt <= mcnt + 4'd1;
    end
  end
  assign sb_out1 = rv[L-1] ? rd[L-1][11:8] : junk;
  assign sb_out2 = rv[L-1] ? rd[L-1][7:4] : ~junk;
  assign sb_out3 = rv[L-1] ? rd[L-1][3:0] : junk ^ 4'h6;
  assign sb_rs_out = rv[0] ? 8'h10 + {4'h0, ridx0} : 8'hEE;
  int en_cnt = 0, runs = 0;
  bit prev_en = 0, stale = 0;
  always @(negedge clk) begin
    if (rst) begin
      en_cnt = 0;
      runs = 0;
      prev_en = 0;
      stale = 0;
    end else begin
      if (sb_en && !prev_en) runs++;
      if (sb_en) en_cnt++;
      prev_en = sb_en;
      if (!sb_en && {sb_in1, sb_in2, sb_in3} != 12'h0) stale = 1;
      if (rv[0]) chk("rs_chain", {56'h0, sb_rs_in}, {56'h0, ridx0 == 4'd0 ? cur_seed : 8'h10 + {4'h0, ridx0} - 8'h1});
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 64'h1, 64'h0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("share1", state_out1, e.o1);
          chk("share2", state_out2, e.o2);
          chk("share3", state_out3, e.o3);
          chk("unmasked", state_out1 ^ state_out2 ^ state_out3, e.x);
          chk("latency", 64'(cyc - e.t0), 64'(N + L + 1));
          chk("busy_at_done", {63'h0, busy}, 64'h0);
          chk("en_cycles", 64'(en_cnt), 64'(N));
          chk("en_runs", 64'(runs), 64'h1);
          chk("stale_bus", {63'h0, stale}, 64'h0);
        end
        en_cnt = 0;
        runs = 0;
        stale = 0;
      end
    end
  end
  task automatic run_layer(input logic [63:0] x, a, b, m2, m3, input logic [7:0] seed, input int dbl, input bit zc);
    exp_t e;
    int k;
    @(negedge clk);
    cur_m2 = m2;
    cur_m3 = m3;
    cur_seed = seed;
    e.o2 = m2;
    e.o3 = m3;
    e.x = layer(x);
    e.o1 = e.x ^ m2 ^ m3;
    e.t0 = cyc;
    q.push_back(e);
    state_in1 = x ^ a ^ b;
    state_in2 = a;
    state_in3 = b;
    rs_seed = seed;
    start = 1;
    @(negedge clk);
    start = 0;
    state_in1 = {$urandom, $urandom};
    state_in2 = {$urandom, $urandom};
    rs_seed = 8'($urandom);
    chk("busy_after_start", {63'h0, busy}, 64'h1);
    if (zc) begin
`ifdef SBOX_SEQ_ZEROIZE_EN
      chk("zeroize", state_out1 | state_out2 | state_out3, 64'h0);
`else
      chk("persist1", state_out1, last_e.o1);
      chk("persist2", state_out2, last_e.o2);
      chk("persist3", state_out3, last_e.o3);
`endif
    end
    if (dbl > 0) begin
      repeat (dbl - 1) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
    end
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 64'h0, 64'h1);
    last_e = e;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [63:0] x, a, b;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_sb_en", {63'h0, sb_en}, 64'h0);
    chk("rst_sb_in", {52'h0, sb_in1, sb_in2, sb_in3}, 64'h0);
    chk("rst_rs_in", {56'h0, sb_rs_in}, 64'h0);
    chk("rst_out", state_out1 | state_out2 | state_out3, 64'h0);
    rst = 0;
    run_layer(64'h0123456789ABCDEF, 64'h0, 64'h0, 64'h0, 64'h0, 8'hA5, 0, 0);
    chk("present_const", state_out1 ^ state_out2 ^ state_out3, 64'hC56B90AD3EF84712);
    run_layer({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 5, 0);
    @(negedge clk);
    state_in1 = {$urandom, $urandom};
    state_in2 = {$urandom, $urandom};
    state_in3 = {$urandom, $urandom};
    cur_m2 = {$urandom, $urandom};
    cur_m3 = {$urandom, $urandom};
    cur_seed = 8'h3C;
    rs_seed = 8'h3C;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_out", state_out1 | state_out2 | state_out3, 64'h0);
    repeat (30) @(negedge clk);
    chk("abort_idle", {63'h0, busy}, 64'h0);
    chk("abort_out_held", state_out1 | state_out2 | state_out3, 64'h0);
    run_layer({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 0, 0);
    run_layer({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 0, 1);
    for (int i = 0; i < 100; i++) begin
      x = {$urandom, $urandom};
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (a == 0) a = 64'h1;
      if (b == 0) b = 64'h2;
      run_layer(x, a, b, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 0, 0);
    end
    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
